// File: rtl/gate_stim_seq_if.sv
// Bundle between the gate stimulus sequencer and its gate/controller side.
// Fail-capture fields exist only when GATE_STIM_FAIL_CAPTURE_EN is defined.
interface gate_stim_seq_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             a;
  logic             b;
  logic             y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
`ifdef GATE_STIM_FAIL_CAPTURE_EN
  logic             fail_valid;
  logic [1:0]       fail_vec;

  modport master (input start, y, output a, b, busy, done, pass, err_cnt, fail_valid, fail_vec);
  modport slave  (output start, y, input a, b, busy, done, pass, err_cnt, fail_valid, fail_vec);
`else
  modport master (input start, y, output a, b, busy, done, pass, err_cnt);
  modport slave  (output start, y, input a, b, busy, done, pass, err_cnt);
`endif
endinterface

// File: rtl/gate_stim_seq.sv
// Sweeps a/b through 00,01,10,11 and checks y==a&b at the end of each hold window.
// Latency: done pulses 4*HOLD_CYCLES*NUM_PASSES cycles after the start edge; no backpressure, start ignored while busy.
// Optional first-mismatch capture (fail_valid/fail_vec) under GATE_STIM_FAIL_CAPTURE_EN.
module gate_stim_seq #(
  parameter int HOLD_CYCLES = 10,
  parameter int NUM_PASSES  = 1,
  parameter int ERR_W       = 8
) (
  input logic            clk,
  input logic            rst_n,
  gate_stim_seq_if.master bus
);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t           state;
  logic [HW-1:0]    hold;
  logic [1:0]       vec;
  logic [PW-1:0]    pass_idx;
  logic             a_q, b_q, busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_q;
  logic             last_hold, mismatch, last_vec;
  logic [ERR_W-1:0] err_nxt;
  logic [1:0]       vec_nxt;

  always_comb begin
    last_hold = (hold == HW'(HOLD_CYCLES - 1));
    mismatch  = (state == DRIVE) && last_hold && (bus.y != (a_q & b_q));
    last_vec  = (vec == 2'd3) && (pass_idx == PW'(NUM_PASSES - 1));
    vec_nxt   = vec + 2'd1;
    err_nxt   = err_q;
    // Saturate so a wrapped counter can never read back as a clean run.
    if (mismatch && (err_q != {ERR_W{1'b1}}))
      err_nxt = err_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= '0;
      vec      <= '0;
      pass_idx <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            state    <= DRIVE;
            hold     <= '0;
            vec      <= '0;
            pass_idx <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        DRIVE: begin
          err_q <= err_nxt;
          if (last_hold) begin
            if (last_vec) begin
              state  <= DONE;
              done_q <= 1'b1;
              pass_q <= (err_nxt == '0);
              a_q    <= 1'b0;
              b_q    <= 1'b0;
            end else begin
              hold <= '0;
              vec  <= vec_nxt;
              a_q  <= vec_nxt[1];
              b_q  <= vec_nxt[0];
              if (vec == 2'd3)
                pass_idx <= pass_idx + PW'(1);
            end
          end else begin
            hold <= hold + HW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a       = a_q;
  assign bus.b       = b_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;

`ifdef GATE_STIM_FAIL_CAPTURE_EN
  logic       fail_valid_q;
  logic [1:0] fail_vec_q;

  // Only the first mismatch of a run is kept; later ones would hide the root cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'b00;
    end else if (state == IDLE && bus.start) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'b00;
    end else if (mismatch && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_vec_q   <= {a_q, b_q};
    end
  end

  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;
`endif
endmodule

// File: tb/tb_gate_stim_seq.sv
// Directed bench for gate_stim_seq: three instances with different hold/pass/width settings
// and a selectable gate model (AND, OR, tied 1, tied 0) on each y input.
module tb_gate_stim_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [1:0] mode0 = 2'd0;
  logic [1:0] mode1 = 2'd2;
  logic [1:0] mode2 = 2'd2;

  always #5 clk = ~clk;

  gate_stim_seq_if #(.ERR_W(8)) if0 ();
  gate_stim_seq_if #(.ERR_W(8)) if1 ();
  gate_stim_seq_if #(.ERR_W(2)) if2 ();

  function automatic logic gate(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign if0.y = gate(mode0, if0.a, if0.b);
  assign if1.y = gate(mode1, if1.a, if1.b);
  assign if2.y = gate(mode2, if2.a, if2.b);

  gate_stim_seq #(.HOLD_CYCLES(10), .NUM_PASSES(1), .ERR_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  gate_stim_seq #(.HOLD_CYCLES(10), .NUM_PASSES(3), .ERR_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
  gate_stim_seq #(.HOLD_CYCLES(3),  .NUM_PASSES(2), .ERR_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0:       if0.start = v;
      1:       if1.start = v;
      default: if2.start = v;
    endcase
  endtask

  function automatic logic done_of(input int s);
    case (s)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  // Leaves the caller at the negedge right after the accepting edge.
  task automatic pulse_start(input int s);
    @(negedge clk);
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
  endtask

  task automatic wait_done(input int s, output int k);
    k = 0;
    while (!done_of(s) && k < 500) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int k;
    logic [1:0] ev;
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_async_out", {if0.a, if0.b, if0.busy, if0.done, if0.pass}, 5'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out", {if0.a, if0.b, if0.busy, if0.done, if0.pass}, 5'b0);
    check("rst_err0", if0.err_cnt, 0);
    check("rst_err2", if2.err_cnt, 0);

    // Good AND gate, full sequence traced, plus a stray start mid-run
    mode0 = 2'd0;
    pulse_start(0);
    for (int c = 0; c < 40; c++) begin
      if (c == 15) if0.start = 1'b1;
      if (c == 16) if0.start = 1'b0;
      ev = 2'(c / 10);
      check($sformatf("and_seq_c%0d", c), {if0.a, if0.b, if0.busy, if0.done}, {ev, 2'b10});
      @(negedge clk);
    end
    check("and_done_frame", {if0.a, if0.b, if0.busy, if0.done}, 4'b0011);
    check("and_pass", if0.pass, 1);
    check("and_err", if0.err_cnt, 0);
    @(negedge clk);
    check("and_idle", {if0.busy, if0.done, if0.pass}, 3'b001);

    // OR gate: mismatches on 01 and 10
    mode0 = 2'd1;
    pulse_start(0);
    check("or_pass_clr", if0.pass, 0);
    wait_done(0, k);
    check("or_len", k, 40);
    check("or_err", if0.err_cnt, 2);
    check("or_pass", if0.pass, 0);
`ifdef GATE_STIM_FAIL_CAPTURE_EN
    check("or_fail_valid", if0.fail_valid, 1);
    check("or_fail_vec", if0.fail_vec, 2'b01);
`endif
    repeat (3) @(negedge clk);
    check("or_retain", {if0.busy, if0.pass, if0.err_cnt}, {2'b00, 8'd2});

    // Asynchronous reset during vector 10
    mode0 = 2'd1;
    pulse_start(0);
    repeat (25) @(negedge clk);
    check("rstmid_vec", {if0.a, if0.b, if0.busy}, 3'b101);
    check("rstmid_err_pre", if0.err_cnt, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_out", {if0.a, if0.b, if0.busy, if0.done, if0.pass}, 5'b0);
    check("rstmid_err", if0.err_cnt, 0);
`ifdef GATE_STIM_FAIL_CAPTURE_EN
    check("rstmid_fail", {if0.fail_valid, if0.fail_vec}, 3'b000);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    mode0 = 2'd0;
    pulse_start(0);
    wait_done(0, k);
    check("rstmid_rerun_len", k, 40);
    check("rstmid_rerun_res", {if0.pass, if0.err_cnt}, {1'b1, 8'd0});

    // start held high: one IDLE cycle between runs, err_cnt cleared on restart
    mode0 = 2'd1;
    @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    wait_done(0, k);
    check("held_len1", k, 40);
    check("held_err1", if0.err_cnt, 2);
    @(negedge clk);
    check("held_idle", {if0.busy, if0.done, if0.err_cnt}, {2'b00, 8'd2});
    @(negedge clk);
    check("held_restart", {if0.busy, if0.err_cnt}, {1'b1, 8'd0});
    if0.start = 1'b0;
    mode0 = 2'd0;
    wait_done(0, k);
    check("held_len2", k, 40);
    check("held_res2", {if0.pass, if0.err_cnt}, {1'b1, 8'd0});

    // y tied 1, three passes: 3 mismatches per pass
    pulse_start(1);
    repeat (40) @(negedge clk);
    check("p3_wrap", {if1.a, if1.b, if1.busy, if1.done}, 4'b0010);
    check("p3_err_mid", if1.err_cnt, 3);
    wait_done(1, k);
    check("p3_len", k + 40, 120);
    check("p3_err", if1.err_cnt, 9);
    check("p3_pass", if1.pass, 0);

    // 2-bit counter: 6 raw mismatches saturate at 3
    mode2 = 2'd2;
    pulse_start(2);
    wait_done(2, k);
    check("sat_len", k, 24);
    check("sat_err", if2.err_cnt, 3);
    check("sat_pass", if2.pass, 0);
    @(negedge clk);

    // y tied 0: only the 11 vector fails, twice
    mode2 = 2'd3;
    pulse_start(2);
    wait_done(2, k);
    check("zero_len", k, 24);
    check("zero_err", if2.err_cnt, 2);
    check("zero_pass", if2.pass, 0);
`ifdef GATE_STIM_FAIL_CAPTURE_EN
    check("zero_fail_vec", {if2.fail_valid, if2.fail_vec}, 3'b111);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
